// File: rtl/scancode2ascii_fifo.sv
// scancode2ascii_fifo: PS/2 set-2 parser with JIS-106 ASCII mapping into a first-word-fall-through FIFO
module scancode2ascii_fifo #(
    parameter int DEPTH         = 8,
    parameter bit DROP_UNMAPPED = 1'b1
) (
    input  logic                     clk,
    input  logic                     i_sclr_n,
    input  logic [7:0]               i_scancode,
    input  logic                     i_valid,
    input  logic                     i_ready,
    output logic [7:0]               o_ascii,
    output logic                     o_valid,
    output logic                     o_shift,
    output logic                     o_capslock,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, BRK = 2'd1, EXT = 2'd2, EXT_BRK = 2'd3;
    logic [1:0] state_q, state_d;
    logic lshift_q, lshift_d, rshift_q, rshift_d, caps_q, caps_d, held_q, held_d;
    logic ign, acc, pre_f0, pre_e0, evt, mk, is_ls, is_rs, is_caps, shift, alpha, push, pop, full, wr, ovf_d;
    logic [7:0] lo, hi, ch, push_ch;
    logic [7:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic ovf_q;
    // state bit 0 marks a pending break, bit 1 an extended prefix
    assign ign     = i_scancode == 8'hE1 || (i_scancode >= 8'hE2 && i_scancode != 8'hF0);
    assign acc     = i_valid && !ign;
    assign pre_f0  = !state_q[0] && i_scancode == 8'hF0;
    assign pre_e0  = state_q == IDLE && i_scancode == 8'hE0;
    assign evt     = acc && !pre_f0 && !pre_e0;
    assign mk      = evt && !state_q[0];
    assign is_ls   = !state_q[1] && i_scancode == 8'h12;
    assign is_rs   = !state_q[1] && i_scancode == 8'h59;
    assign is_caps = !state_q[1] && i_scancode == 8'h58;
    assign state_d = !acc ? state_q : pre_f0 ? {state_q[1], 1'b1} : pre_e0 ? EXT : IDLE;
    assign lshift_d = evt && is_ls ? mk : lshift_q;
    assign rshift_d = evt && is_rs ? mk : rshift_q;
    assign held_d   = evt && is_caps ? mk : held_q;
    assign caps_d   = caps_q ^ (mk && is_caps && !held_q);
    always_comb begin
        lo = 8'h00;
        hi = 8'h00;
        if (state_q[1]) begin
            lo = i_scancode == 8'h5A ? 8'h0D : i_scancode == 8'h4A ? 8'h2F : 8'h00;
            hi = lo;
        end else begin
            case (i_scancode)
                8'h1C: {lo, hi} = "aA";
                8'h32: {lo, hi} = "bB";
                8'h21: {lo, hi} = "cC";
                8'h23: {lo, hi} = "dD";
                8'h24: {lo, hi} = "eE";
                8'h2B: {lo, hi} = "fF";
                8'h34: {lo, hi} = "gG";
                8'h33: {lo, hi} = "hH";
                8'h43: {lo, hi} = "iI";
                8'h3B: {lo, hi} = "jJ";
                8'h42: {lo, hi} = "kK";
                8'h4B: {lo, hi} = "lL";
                8'h3A: {lo, hi} = "mM";
                8'h31: {lo, hi} = "nN";
                8'h44: {lo, hi} = "oO";
                8'h4D: {lo, hi} = "pP";
                8'h15: {lo, hi} = "qQ";
                8'h2D: {lo, hi} = "rR";
                8'h1B: {lo, hi} = "sS";
                8'h2C: {lo, hi} = "tT";
                8'h3C: {lo, hi} = "uU";
                8'h2A: {lo, hi} = "vV";
                8'h1D: {lo, hi} = "wW";
                8'h22: {lo, hi} = "xX";
                8'h35: {lo, hi} = "yY";
                8'h1A: {lo, hi} = "zZ";
                8'h16: {lo, hi} = "1!";
                8'h1E: {lo, hi} = "2\"";
                8'h26: {lo, hi} = "3#";
                8'h25: {lo, hi} = "4$";
                8'h2E: {lo, hi} = "5%";
                8'h36: {lo, hi} = "6&";
                8'h3D: {lo, hi} = "7'";
                8'h3E: {lo, hi} = "8(";
                8'h46: {lo, hi} = "9)";
                8'h45: {lo, hi} = {"0", 8'h00};
                8'h4E: {lo, hi} = "-=";
                8'h55: {lo, hi} = "^~";
                8'h6A: {lo, hi} = "\\|";
                8'h54: {lo, hi} = {"@", 8'h60};
                8'h5B: {lo, hi} = "[{";
                8'h4C: {lo, hi} = ";+";
                8'h52: {lo, hi} = ":*";
                8'h5D: {lo, hi} = "]}";
                8'h41: {lo, hi} = ",<";
                8'h49: {lo, hi} = ".>";
                8'h4A: {lo, hi} = "/?";
                8'h51: {lo, hi} = "__";
                8'h29: {lo, hi} = "  ";
                8'h66: {lo, hi} = 16'h0808;
                8'h5A: {lo, hi} = 16'h0D0D;
                8'h76: {lo, hi} = 16'h1B1B;
                default: ;
            endcase
        end
    end
    assign shift   = lshift_q | rshift_q;
    assign alpha   = lo >= "a" && lo <= "z";
    assign ch      = (alpha ? shift ^ caps_q : shift) ? hi : lo;
    assign push    = mk && !(is_ls || is_rs || is_caps) && (ch != 8'h00 || !DROP_UNMAPPED);
    assign push_ch = ch != 8'h00 ? ch : 8'hFF;
    assign o_valid = cnt_q != '0;
    assign pop     = o_valid && i_ready;
    assign full    = cnt_q == FULL;
    assign wr      = push && (!full || pop);
    assign wr_d    = wr ? wr_q + AW'(1) : wr_q;
    assign rd_d    = pop ? rd_q + AW'(1) : rd_q;
    assign cnt_d   = cnt_q + (AW + 1)'(wr) - (AW + 1)'(pop);
    assign ovf_d   = ovf_q || (push && full && !pop);
    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            state_q  <= IDLE;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            caps_q   <= 1'b0;
            held_q   <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            caps_q   <= caps_d;
            held_q   <= held_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (i_sclr_n && wr) mem_q[wr_q] <= push_ch;
    end
    assign o_ascii    = o_valid ? mem_q[rd_q] : 8'h00;
    assign o_shift    = shift;
    assign o_capslock = caps_q;
    assign o_count    = cnt_q;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_scancode2ascii_fifo.sv
// tb_scancode2ascii_fifo: directed-vector bench for scancode2ascii_fifo
module tb_scancode2ascii_fifo;
    logic clk = 1'b0, sclr_n = 1'b0, valid = 1'b0, ready = 1'b0;
    logic [7:0] code = 8'h00;
    logic [7:0] a0, a1;
    logic v0, v1, s0, s1, c0, c1, f0, f1;
    logic [3:0] n0, n1;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    scancode2ascii_fifo #(.DEPTH(8), .DROP_UNMAPPED(1'b1)) dut (
        .clk(clk), .i_sclr_n(sclr_n), .i_scancode(code), .i_valid(valid), .i_ready(ready),
        .o_ascii(a0), .o_valid(v0), .o_shift(s0), .o_capslock(c0), .o_count(n0), .o_overflow(f0));
    scancode2ascii_fifo #(.DEPTH(8), .DROP_UNMAPPED(1'b0)) dut_keep (
        .clk(clk), .i_sclr_n(sclr_n), .i_scancode(code), .i_valid(valid), .i_ready(ready),
        .o_ascii(a1), .o_valid(v1), .o_shift(s1), .o_capslock(c1), .o_count(n1), .o_overflow(f1));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        code = b;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask
    task automatic pop(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(v0), 32'd1);
        chk(tag, 32'(a0), 32'(exp));
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask
    task automatic rst;
        @(negedge clk);
        sclr_n = 1'b0;
        @(negedge clk);
        sclr_n = 1'b1;
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_count", 32'(n0), 32'd0);
        chk("rst_ascii", 32'(a0), 32'h00);
        chk("rst_ovf", 32'(f0), 32'd0);
        chk("rst_shift", 32'(s0), 32'd0);
        chk("rst_caps", 32'(c0), 32'd0);
        sclr_n = 1'b1;
        ready = 1'b1;
        send(8'h1C);
        chk("a_valid", 32'(v0), 32'd1);
        chk("a_ascii", 32'(a0), 32'h61);
        @(negedge clk);
        chk("a_popped_valid", 32'(v0), 32'd0);
        send(8'hF0);
        send(8'h1C);
        chk("a_break_count", 32'(n0), 32'd0);
        ready = 1'b0;
        send(8'h12);
        chk("lshift_on", 32'(s0), 32'd1);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        chk("lshift_off", 32'(s0), 32'd0);
        send(8'h1C);
        chk("shift_count", 32'(n0), 32'd2);
        pop("shift_A", 8'h41);
        pop("shift_a", 8'h61);
        chk("shift_empty", 32'(n0), 32'd0);
        send(8'h58);
        chk("caps_on", 32'(c0), 32'd1);
        send(8'h58);
        send(8'h58);
        chk("caps_repeat", 32'(c0), 32'd1);
        send(8'hF0);
        send(8'h58);
        chk("caps_hold_count", 32'(n0), 32'd0);
        send(8'h1C);
        pop("caps_A", 8'h41);
        rst();
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        send(8'h12);
        send(8'h1C);
        pop("caps_shift_a", 8'h61);
        rst();
        for (int i = 0; i < 8; i++) send(8'h16);
        chk("fill_count", 32'(n0), 32'd8);
        chk("fill_ovf", 32'(f0), 32'd0);
        send(8'h16);
        chk("over_count", 32'(n0), 32'd8);
        chk("over_ovf", 32'(f0), 32'd1);
        @(negedge clk);
        code = 8'h1E;
        valid = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        ready = 1'b0;
        chk("full_pushpop_count", 32'(n0), 32'd8);
        for (int i = 0; i < 7; i++) pop("drain_1", 8'h31);
        pop("drain_2", 8'h32);
        chk("drain_empty", 32'(v0), 32'd0);
        chk("ovf_sticky", 32'(f0), 32'd1);
        rst();
        chk("ovf_cleared", 32'(f0), 32'd0);
        send(8'hE0);
        send(8'h5A);
        send(8'hE0);
        send(8'hF0);
        send(8'h5A);
        chk("ext_count", 32'(n0), 32'd1);
        pop("ext_enter", 8'h0D);
        send(8'h12);
        send(8'hE0);
        send(8'hF0);
        send(8'h12);
        chk("ext_brk_shift", 32'(s0), 32'd1);
        send(8'h1C);
        pop("ext_shift_A", 8'h41);
        send(8'hE0);
        send(8'h4A);
        pop("ext_slash", 8'h2F);
        rst();
        send(8'h0E);
        chk("drop_count", 32'(n0), 32'd0);
        chk("keep_count", 32'(n1), 32'd1);
        chk("keep_ff", 32'(a1), 32'hFF);
        rst();
        send(8'hF0);
        rst();
        send(8'h1C);
        pop("rst_prefix_a", 8'h61);
        send(8'hF0);
        send(8'hE1);
        send(8'hFA);
        send(8'h1C);
        chk("ign_break_count", 32'(n0), 32'd0);
        send(8'h1C);
        pop("ign_make_a", 8'h61);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scancode2ascii_fifo.md
SCANCODE2ASCII_FIFO -- requirements
Module: scancode2ascii_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning output FIFO depth in characters (power of two, >=2).
REQ-002 SHALL have parameter DROP_UNMAPPED, default 1, meaning 1 = discard unmapped make codes, 0 = enqueue 8'hFF for them.
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port i_sclr_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_scancode  in  8  PS/2 set-2 byte from the receiver.
REQ-006 SHALL have port i_valid  in  1  one-cycle strobe qualifying i_scancode.
REQ-007 SHALL have port i_ready  in  1  consumer accepts o_ascii this cycle.
REQ-008 SHALL have port o_ascii  out  8  FIFO head character.
REQ-009 SHALL have port o_valid  out  1  FIFO non-empty; o_ascii meaningful.
REQ-010 SHALL have port o_shift  out  1  left OR right shift currently held.
REQ-011 SHALL have port o_capslock  out  1  caps-lock latch state.
REQ-012 SHALL have port o_count  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-013 SHALL have port o_overflow  out  1  sticky: a character was dropped because the FIFO was full.

Function
REQ-014 Parser FSM states SHALL be IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen); only i_valid cycles advance it.
REQ-015 Transitions: IDLE--F0-->BRK, IDLE--E0-->EXT, EXT--F0-->EXT_BRK; any other byte in IDLE/EXT is a make; any byte in BRK/EXT_BRK is a break; after a make/break the FSM SHALL return to IDLE.
REQ-016 Byte E1 and any byte in 8'hE2..8'hFF except F0 SHALL be ignored, FSM unchanged.
REQ-017 Modifiers: make 12 sets lshift, break 12 clears; make 59 sets rshift, break 59 clears; o_shift = lshift|rshift.
REQ-018 Caps-lock: make 58 SHALL toggle o_capslock only when caps_held=0, then set caps_held; break 58 clears caps_held (typematic repeats do not re-toggle).
REQ-019 Modifier and caps makes/breaks SHALL never enqueue a character; breaks of any key SHALL never enqueue.
REQ-020 Mapping SHALL use the team JIS-106 set-2 table: letters (e.g. 1C='a') upper-case when shift XOR capslock; digits/symbols (e.g. 16='1'/'!', 45='0' unshifted-only) select by shift alone; 66->08, 5A->0D, 29->20, 76->1B, 51->5F.
REQ-021 Extended makes SHALL map E0 5A->0D and E0 4A->2F; all other extended codes are unmapped.
REQ-022 Mapping SHALL use modifier state as held before the current byte.
REQ-023 Unmapped non-modifier makes: dropped if DROP_UNMAPPED=1, else enqueue 8'hFF.
REQ-024 Latency: a mapped make on cycle N SHALL be written at the edge ending N; with FIFO empty, o_valid=1 and o_ascii valid in cycle N+1 (first-word fall-through).
REQ-025 Pop SHALL occur on any cycle with o_valid & i_ready; o_ascii advances next cycle.
REQ-026 Push with FIFO full and no pop SHALL drop the character, keep contents unchanged, and set o_overflow.
REQ-027 Push and pop in the same cycle SHALL both succeed at any occupancy including full and empty (empty: no pop occurs, push succeeds); o_count unchanged when both happen.
REQ-028 Pointers SHALL wrap modulo DEPTH; o_count SHALL range 0..DEPTH exactly.

Reset
REQ-029 While i_sclr_n=0 at a clock edge: FSM->IDLE, lshift/rshift/caps_held/o_capslock=0, pointers and o_count=0, o_valid=0, o_overflow=0, o_ascii=8'h00.
REQ-030 Reset mid-sequence (after F0 or E0) SHALL discard the prefix; next byte is parsed from IDLE.
REQ-031 o_overflow SHALL clear only by reset.

Verification
REQ-032 Bytes 1C, F0,1C, i_ready=1 -> exactly one 8'h61 with o_valid for one cycle, o_count back to 0.
REQ-033 Bytes 12,1C,F0,1C,F0,12,1C -> queue 8'h41, 8'h61; o_shift 1 then 0.
REQ-034 Bytes 58,58,58,F0,58,1C -> o_capslock=1 after first 58 only; then 8'h41; bytes 58,F0,58,12,1C -> 8'h61.
REQ-035 DEPTH=8, i_ready=0, 9 makes of 16 -> o_count=8, o_overflow=1, drain yields eight 8'h31.
REQ-036 E0,5A then E0,F0,5A -> one 8'h0D; E0 F0 12 does not clear lshift-independent state; 0E (unmapped) with DROP_UNMAPPED=0 -> 8'hFF.
REQ-037 Bytes F0, reset pulse, 1C -> 8'h61 enqueued (no break applied).
